// File: rtl/mips_pkg.sv
// mips_pkg -- constants and types shared by the instruction-fetch slice.
//   NOP       : instruction word delivered in place of a squashed fetch
//   PC_INC    : byte distance between consecutive instruction words
//   fetch_state_t : FETCH (request outstanding) / HOLD (word parked, no request)
//   next_pc   : sequential successor of a PC, wrapping modulo 2^32
//   align_pc  : force a redirect address onto a word boundary
package mips_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if -- instruction-memory port of the fetch stage.
//   imem_req   : fetch stage is asking for the word at imem_addr
//   imem_addr  : word-aligned fetch address (the current PC)
//   imem_ready : memory side says imem_rdata is valid for imem_addr this cycle
//   imem_rdata : instruction word
// Handshake: a word is consumed on a rising clock edge where imem_req and
// imem_ready are both high; imem_addr stays put until that happens (or until
// a redirect/reset moves it). imem_ready seen while imem_req is low is ignored.
// Modports: master = fetch stage, slave = instruction memory.
interface ifetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_skid.sv
// ifetch_skid -- one-entry buffer for a fetched word that arrived while the
// decode stage was stalled.
//   clk, reset : clock, synchronous active-low reset
//   load       : capture load_instr/load_addr and mark full
//   drain      : entry has been handed downstream; mark empty
//   clear      : discard the entry (redirect)
//   load_instr, load_addr : incoming instruction and its PC+4
//   instr, addr, full     : stored entry and occupancy flag
// Priority: reset, clear, load, drain.
module ifetch_skid
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_addr,
  output logic [31:0] instr,
  output logic [31:0] addr,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      instr <= NOP;
      addr  <= 32'h0000_0000;
      full  <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      addr  <= load_addr;
      full  <= 1'b1;
    end else if (drain) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch -- instruction-fetch stage feeding the IF/ID register.
// Parameter RESET_VECTOR : PC loaded by reset.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   stall                 : decode hazard; IF/ID outputs frozen while high
//   branch_taken/_target  : redirect from a later stage (overrides stall)
//   imem                  : instruction-memory port (ifetch_if.master)
//   addressout            : PC+4 of the delivered instruction
//   instructionout        : delivered instruction
//   validout              : addressout/instructionout carry a real instruction
//   fsm_state             : current FETCH/HOLD state, for observation
//   fetch_stall_cnt       : only with IFETCH_PERF_CNT_EN defined; saturating
//                           count of cycles spent in HOLD or waiting on memory
// A word arriving while stalled is parked in ifetch_skid and the stage stops
// requesting (HOLD) until the stall lifts, so no memory response is lost.
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  ifetch_if.master     imem,
  output logic [31:0]  addressout,
  output logic [31:0]  instructionout,
  output logic         validout,
  output fetch_state_t fsm_state
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_stall_cnt
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;

  logic         skid_load;
  logic         skid_drain;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_addr;
  logic         skid_full;

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign fsm_state      = state;

  // A redirect wins over everything, so a word returned in the redirect
  // cycle never reaches the buffer.
  assign skid_load  = !branch_taken && (state == FETCH) && imem.imem_ready && stall;
  assign skid_drain = !branch_taken && (state == HOLD) && !stall;

  ifetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (branch_taken),
    .load_instr (imem.imem_rdata),
    .load_addr  (next_pc(pc)),
    .instr      (skid_instr),
    .addr       (skid_addr),
    .full       (skid_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= FETCH;
      pc             <= RESET_VECTOR;
      addressout     <= 32'h0000_0000;
      instructionout <= NOP;
      validout       <= 1'b0;
    end else if (branch_taken) begin
      state          <= FETCH;
      pc             <= align_pc(branch_target);
      addressout     <= 32'h0000_0000;
      instructionout <= NOP;
      validout       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            pc <= next_pc(pc);
            if (stall) begin
              state <= HOLD;
            end else begin
              addressout     <= next_pc(pc);
              instructionout <= imem.imem_rdata;
              validout       <= 1'b1;
            end
          end else if (!stall) begin
            // Bubble into decode while memory is busy.
            validout <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            addressout     <= skid_addr;
            instructionout <= skid_instr;
            validout       <= skid_full;
            state          <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= 32'h0000_0000;
    end else if (((state == HOLD) || !imem.imem_ready) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  import mips_pkg::*;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         branch_taken;
  logic [31:0]  branch_target;

  logic [31:0]  addressout, instructionout;
  logic         validout;
  fetch_state_t fsm_state;
  logic [31:0]  w_addressout, w_instructionout;
  logic         w_validout;
  fetch_state_t w_fsm_state;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]  fetch_stall_cnt, w_fetch_stall_cnt;
`endif

  int n_checks;
  int n_fail;

  ifetch_if bus ();
  ifetch_if wbus ();

  ifetch u_dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (bus),
    .addressout     (addressout),
    .instructionout (instructionout),
    .validout       (validout),
    .fsm_state      (fsm_state)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );

  ifetch #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (wbus),
    .addressout     (w_addressout),
    .instructionout (w_instructionout),
    .validout       (w_validout),
    .fsm_state      (w_fsm_state)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt(w_fetch_stall_cnt)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; inputs are driven and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    reset = 1'b0;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    n_checks++; if (validout !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", validout); end
    n_checks++; if (addressout !== 32'h0) begin n_fail++; $display("FAIL reset_addressout: got %h expected 00000000", addressout); end
    n_checks++; if (instructionout !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instructionout); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", bus.imem_addr); end
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %0b expected 1", bus.imem_req); end
    n_checks++; if (fsm_state !== FETCH) begin n_fail++; $display("FAIL reset_state: got %0d expected FETCH", fsm_state); end
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h2008_0005;
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_addr0: got %h expected 00000000", bus.imem_addr); end
    tick();
    n_checks++; if (validout !== 1'b1) begin n_fail++; $display("FAIL seq_valid: got %0b expected 1", validout); end
    n_checks++; if (addressout !== 32'h4) begin n_fail++; $display("FAIL seq_addressout1: got %h expected 00000004", addressout); end
    n_checks++; if (instructionout !== 32'h2008_0005) begin n_fail++; $display("FAIL seq_instr: got %h expected 20080005", instructionout); end
    n_checks++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr1: got %h expected 00000004", bus.imem_addr); end
    tick();
    n_checks++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr2: got %h expected 00000008", bus.imem_addr); end
    n_checks++; if (addressout !== 32'h8) begin n_fail++; $display("FAIL seq_addressout2: got %h expected 00000008", addressout); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1111_0000;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL hold_pc_start: got %h expected 00000010", bus.imem_addr); end
    stall = 1'b1; bus.imem_rdata = 32'h2222_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.imem_rdata = 32'hBAD0_0000 + i;
      n_checks++; if (fsm_state !== HOLD) begin n_fail++; $display("FAIL hold_state[%0d]: got %0d expected HOLD", i, fsm_state); end
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %0b expected 0", i, bus.imem_req); end
      n_checks++; if (addressout !== 32'h10) begin n_fail++; $display("FAIL hold_addressout[%0d]: got %h expected 00000010", i, addressout); end
      n_checks++; if (instructionout !== 32'h1111_0000) begin n_fail++; $display("FAIL hold_instr[%0d]: got %h expected 11110000", i, instructionout); end
      n_checks++; if (validout !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %0b expected 1", i, validout); end
    end
    stall = 1'b0;
    tick();
    n_checks++; if (addressout !== 32'h14) begin n_fail++; $display("FAIL release_addressout: got %h expected 00000014", addressout); end
    n_checks++; if (instructionout !== 32'h2222_0010) begin n_fail++; $display("FAIL release_instr: got %h expected 22220010", instructionout); end
    n_checks++; if (validout !== 1'b1) begin n_fail++; $display("FAIL release_valid: got %0b expected 1", validout); end
    n_checks++; if (bus.imem_addr !== 32'h14) begin n_fail++; $display("FAIL release_fetch_addr: got %h expected 00000014", bus.imem_addr); end
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %0b expected 1", bus.imem_req); end
    bus.imem_rdata = 32'h3333_0014;
    tick();
    n_checks++; if (addressout !== 32'h18) begin n_fail++; $display("FAIL after_release_addressout: got %h expected 00000018", addressout); end
    n_checks++; if (instructionout !== 32'h3333_0014) begin n_fail++; $display("FAIL after_release_instr: got %h expected 33330014", instructionout); end
  endtask

  task automatic test_branch();
    // starts at PC=0x18 in FETCH with valid outputs
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0103;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h4444_4444;
    tick();
    branch_taken = 1'b0;
    n_checks++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_addr: got %h expected 00000100", bus.imem_addr); end
    n_checks++; if (validout !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %0b expected 0", validout); end
    n_checks++; if (instructionout !== 32'h0) begin n_fail++; $display("FAIL br_instr: got %h expected 00000000", instructionout); end
    n_checks++; if (addressout !== 32'h0) begin n_fail++; $display("FAIL br_addressout: got %h expected 00000000", addressout); end
    n_checks++; if (fsm_state !== FETCH) begin n_fail++; $display("FAIL br_state: got %0d expected FETCH", fsm_state); end
    stall = 1'b0; bus.imem_rdata = 32'h5555_0100;
    tick();
    n_checks++; if (addressout !== 32'h104) begin n_fail++; $display("FAIL br_next_addressout: got %h expected 00000104", addressout); end
    n_checks++; if (instructionout !== 32'h5555_0100) begin n_fail++; $display("FAIL br_next_instr: got %h expected 55550100", instructionout); end
    // redirect while parked in HOLD also drops the parked word
    stall = 1'b1; bus.imem_rdata = 32'h6666_0104;
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    branch_taken = 1'b0;
    n_checks++; if (fsm_state !== FETCH) begin n_fail++; $display("FAIL br_hold_state: got %0d expected FETCH", fsm_state); end
    n_checks++; if (bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL br_hold_addr: got %h expected 00000200", bus.imem_addr); end
    stall = 1'b0; bus.imem_rdata = 32'h7777_0200;
    tick();
    n_checks++; if (instructionout !== 32'h7777_0200) begin n_fail++; $display("FAIL br_hold_next_instr: got %h expected 77770200", instructionout); end
  endtask

  task automatic test_wrap();
    wbus.imem_ready = 1'b1; wbus.imem_rdata = 32'hC0DE_0001;
    do_reset();
    n_checks++; if (wbus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first_addr: got %h expected fffffffc", wbus.imem_addr); end
    tick();
    n_checks++; if (wbus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h expected 00000000", wbus.imem_addr); end
    n_checks++; if (w_addressout !== 32'h0) begin n_fail++; $display("FAIL wrap_addressout: got %h expected 00000000", w_addressout); end
    n_checks++; if (w_validout !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %0b expected 1", w_validout); end
  endtask

  task automatic test_wait();
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] cnt0;
`endif
    do_reset();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_1234;
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL wait_pc_start: got %h expected 00000020", bus.imem_addr); end
`ifdef IFETCH_PERF_CNT_EN
    cnt0 = fetch_stall_cnt;
`endif
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL wait_addr[%0d]: got %h expected 00000020", i, bus.imem_addr); end
      n_checks++; if (validout !== 1'b0) begin n_fail++; $display("FAIL wait_valid[%0d]: got %0b expected 0", i, validout); end
    end
`ifdef IFETCH_PERF_CNT_EN
    n_checks++; if (fetch_stall_cnt - cnt0 !== 32'd4) begin n_fail++; $display("FAIL wait_stall_cnt: got %0d expected 4", fetch_stall_cnt - cnt0); end
`endif
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_5678;
    tick();
    n_checks++; if (addressout !== 32'h24) begin n_fail++; $display("FAIL wait_done_addressout: got %h expected 00000024", addressout); end
    n_checks++; if (instructionout !== 32'h0000_5678) begin n_fail++; $display("FAIL wait_done_instr: got %h expected 00005678", instructionout); end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'hAAAA_0000;
    tick(); tick();
    stall = 1'b1; bus.imem_rdata = 32'hBBBB_0008;
    tick();
    n_checks++; if (fsm_state !== HOLD) begin n_fail++; $display("FAIL rih_state_hold: got %0d expected HOLD", fsm_state); end
    reset = 1'b0;
    tick();
    n_checks++; if (fsm_state !== FETCH) begin n_fail++; $display("FAIL rih_state: got %0d expected FETCH", fsm_state); end
    n_checks++; if (validout !== 1'b0) begin n_fail++; $display("FAIL rih_valid: got %0b expected 0", validout); end
    n_checks++; if (addressout !== 32'h0) begin n_fail++; $display("FAIL rih_addressout: got %h expected 00000000", addressout); end
    n_checks++; if (instructionout !== 32'h0) begin n_fail++; $display("FAIL rih_instr: got %h expected 00000000", instructionout); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rih_pc: got %h expected 00000000", bus.imem_addr); end
    reset = 1'b1; stall = 1'b0; bus.imem_rdata = 32'hCCCC_0000;
    tick();
    n_checks++; if (addressout !== 32'h4) begin n_fail++; $display("FAIL rih_next_addressout: got %h expected 00000004", addressout); end
    n_checks++; if (instructionout !== 32'hCCCC_0000) begin n_fail++; $display("FAIL rih_next_instr: got %h expected cccc0000", instructionout); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    wbus.imem_ready = 1'b1; wbus.imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_branch();
    test_wrap();
    test_wait();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
